// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier / product-accumulator pair.
package mult_pkg;

    localparam int DEF_PRODUCT_WIDTH = 16;
    localparam int DEF_ACC_WIDTH     = 24;
    localparam int DEF_COUNT_WIDTH   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums unsigned product terms over a frame and presents the frame result through a
// valid/ready output register. Sum wraps, count saturates, and either event is flagged.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PRODUCT_WIDTH-1:0] in_product,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic [COUNT_WIDTH-1:0]   out_count,
    output logic                     out_overflow
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    // Wrapping add; the extra top bit is the carry out.
    function automatic logic [ACC_WIDTH:0] add_wrap(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [PRODUCT_WIDTH-1:0] p);
        return {1'b0, a} + {1'b0, ACC_WIDTH'(p)};
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (c == COUNT_MAX) ? c : c + 1'b1;
    endfunction

    acc_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   flag_q, flag_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                   out_overflow_q, out_overflow_d;

    logic                   in_fire;
    logic                   out_fire;
    logic [ACC_WIDTH:0]     sum_ext;
    logic [ACC_WIDTH-1:0]   new_acc;
    logic [COUNT_WIDTH-1:0] new_count;
    logic                   new_flag;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        sum_ext = add_wrap(acc_q, in_product);
        if (state_q == IDLE) begin
            new_acc   = ACC_WIDTH'(in_product);
            new_count = COUNT_WIDTH'(1);
            new_flag  = 1'b0;
        end else begin
            new_acc   = sum_ext[ACC_WIDTH-1:0];
            new_count = sat_inc(count_q);
            new_flag  = flag_q || sum_ext[ACC_WIDTH] || (count_q == COUNT_MAX);
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        flag_d         = flag_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        // A last term may land in the same cycle the old result drains: reload, no bubble.
        if (in_fire) begin
            if (in_last) begin
                state_d        = IDLE;
                acc_d          = '0;
                count_d        = '0;
                flag_d         = 1'b0;
                out_valid_d    = 1'b1;
                out_sum_d      = new_acc;
                out_count_d    = new_count;
                out_overflow_d = new_flag;
            end else begin
                state_d = ACCUM;
                acc_d   = new_acc;
                count_d = new_count;
                flag_d  = new_flag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            count_q        <= '0;
            flag_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            flag_q         <= flag_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: default, 16-bit-accumulator and 2-bit-counter instances share one stimulus.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_product;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [23:0] a_out_sum;
    logic [7:0]  a_out_count;

    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [15:0] b_out_sum;
    logic [7:0]  b_out_count;

    logic        c_in_ready, c_out_valid, c_out_overflow;
    logic [23:0] c_out_sum;
    logic [1:0]  c_out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
        .out_overflow(a_out_overflow)
    );

    product_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(16), .COUNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
        .out_overflow(b_out_overflow)
    );

    product_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .COUNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_product(in_product), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_sum(c_out_sum), .out_count(c_out_count),
        .out_overflow(c_out_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one term and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] p, input logic l);
        int n = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = l;
        @(negedge clk);
        while (!a_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accepted", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_sum", 32'(a_out_sum), 32'd0);
        check("rst_out_count", 32'(a_out_count), 32'd0);
        check("rst_out_overflow", 32'(a_out_overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_a", 32'(a_in_ready), 32'd1);
        check("rst_in_ready_b", 32'(b_in_ready), 32'd1);
        check("rst_in_ready_c", 32'(c_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Frame 3,5,7
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'd7, 1'b1);
        check("f357_valid", 32'(a_out_valid), 32'd1);
        check("f357_sum", 32'(a_out_sum), 32'd15);
        check("f357_count", 32'(a_out_count), 32'd3);
        check("f357_ovf", 32'(a_out_overflow), 32'd0);
        check("f357_c_count", 32'(c_out_count), 32'd3);
        check("f357_c_ovf", 32'(c_out_overflow), 32'd0);
        check("f357_b_sum", 32'(b_out_sum), 32'd15);
        @(posedge clk);
        #1;
        check("f357_drained", 32'(a_out_valid), 32'd0);

        // Carry out of the accumulator
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
        check("carry_b_sum", 32'(b_out_sum), 32'h0001);
        check("carry_b_ovf", 32'(b_out_overflow), 32'd1);
        check("carry_b_count", 32'(b_out_count), 32'd2);
        check("carry_a_sum", 32'(a_out_sum), 32'h10001);
        check("carry_a_ovf", 32'(a_out_overflow), 32'd0);
        check("carry_b_valid", 32'(b_out_valid), 32'd1);

        // Five 1s: saturates the 2-bit counter
        for (int i = 0; i < 5; i++) send(16'd1, (i == 4));
        check("sat_c_count", 32'(c_out_count), 32'd3);
        check("sat_c_sum", 32'(c_out_sum), 32'd5);
        check("sat_c_ovf", 32'(c_out_overflow), 32'd1);
        check("sat_a_count", 32'(a_out_count), 32'd5);
        check("sat_a_ovf", 32'(a_out_overflow), 32'd0);
        @(posedge clk);
        #1;

        // Back-pressure: result held, next frame's first term waits
        out_ready = 1'b0;
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        in_valid   = 1'b1;
        in_product = 16'd100;
        in_last    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(a_out_valid), 32'd1);
            check("hold_sum", 32'(a_out_sum), 32'd3);
            check("hold_count", 32'(a_out_count), 32'd2);
            check("hold_in_ready", 32'(a_in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_drained", 32'(a_out_valid), 32'd0);
        send(16'd50, 1'b1);
        check("held_term_sum", 32'(a_out_sum), 32'd150);
        check("held_term_count", 32'(a_out_count), 32'd2);
        @(posedge clk);
        #1;

        // Back-to-back single-term frames
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_product = 16'(10 * i);
            @(posedge clk);
            #1;
            check("b2b_valid", 32'(a_out_valid), 32'd1);
            check("b2b_sum", 32'(a_out_sum), 32'(10 * i));
            check("b2b_count", 32'(a_out_count), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_drained", 32'(a_out_valid), 32'd0);

        // Reset mid-frame
        send(16'd4, 1'b0);
        send(16'd4, 1'b0);
        pulse_reset();
        send(16'd9, 1'b1);
        check("midrst_sum", 32'(a_out_sum), 32'd9);
        check("midrst_count", 32'(a_out_count), 32'd1);
        @(posedge clk);
        #1;

        // Reset with a pending result
        out_ready = 1'b0;
        send(16'd8, 1'b1);
        check("pend_valid_before", 32'(a_out_valid), 32'd1);
        pulse_reset();
        check("pend_valid_after", 32'(a_out_valid), 32'd0);
        check("pend_sum_after", 32'(a_out_sum), 32'd0);
        check("pend_in_ready", 32'(a_in_ready), 32'd1);
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter PRODUCT_WIDTH, default 16, width of incoming products (equals a0_width + a1_width of the upstream multiplier).
REQ-002 The block SHALL have parameter ACC_WIDTH, default 24, accumulator and result width; ACC_WIDTH >= PRODUCT_WIDTH.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 8, width of the per-frame term counter.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_product/in_last valid this cycle.
REQ-008 in_ready  output  1  block accepts a term this cycle.
REQ-009 in_product  input  PRODUCT_WIDTH  unsigned product term.
REQ-010 in_last  input  1  term is the final one of its frame.
REQ-011 out_valid  output  1  out_sum/out_count/out_overflow valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 out_sum  output  ACC_WIDTH  frame sum, modulo 2^ACC_WIDTH.
REQ-014 out_count  output  COUNT_WIDTH  number of terms in frame, saturating.
REQ-015 out_overflow  output  1  sum carry-out or count saturation occurred in frame.

Function
REQ-016 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational; no dependence on in_valid).
REQ-018 FSM SHALL have states IDLE (no partial frame) and ACCUM (partial frame held); accepted non-last term: IDLE->ACCUM, ACCUM->ACCUM; accepted last term: any->IDLE.
REQ-019 First term of a frame (state IDLE) SHALL load acc = zero-extended in_product, count = 1, flag = 0; later terms SHALL add zero-extended in_product to acc and increment count.
REQ-020 Carry out of ACC_WIDTH SHALL set the sticky frame flag; acc wraps modulo 2^ACC_WIDTH.
REQ-021 count SHALL saturate at 2^COUNT_WIDTH-1; an accepted term at saturation SHALL set the flag.
REQ-022 On an accepted in_last term, the output register SHALL load the sum/count/flag including that term, and out_valid SHALL be 1 the following cycle (latency 1).
REQ-023 A single-term frame (in_last on IDLE) SHALL produce out_sum = in_product, out_count = 1.
REQ-024 out_valid SHALL hold and out_* SHALL remain stable until output handshake.
REQ-025 Output handshake with no simultaneous in_last acceptance SHALL clear out_valid next cycle.
REQ-026 Output handshake and in_last acceptance in the same cycle SHALL reload out_* with the new frame and keep out_valid = 1 (back-to-back, no bubble).
REQ-027 Accumulation of a partial frame SHALL continue while out_valid is held only if in_ready = 1; when in_ready = 0 no input state changes.
REQ-028 in_valid with in_ready = 0 SHALL be ignored; upstream holds the term.

Reset
REQ-029 While rst = 1: state = IDLE, acc = 0, count = 0, flag = 0, out_valid = 0, out_sum = 0, out_count = 0, out_overflow = 0; in_ready = 1 in the cycle after reset.
REQ-030 Reset mid-frame or with out_valid pending SHALL discard partial sum and pending result.

Structure
REQ-031 Shared package mult_pkg SHALL hold default PRODUCT_WIDTH/ACC_WIDTH/COUNT_WIDTH constants and the FSM state type.
REQ-032 No sub-module: accumulator datapath, counter and output register SHALL be in one module; instantiation beside multiplier is the parent's task.

Verification
REQ-033 Frame 3,5,7 (last on 7), out_ready = 1 -> out_valid one cycle after the 7 is accepted, out_sum = 15, out_count = 3, out_overflow = 0.
REQ-034 ACC_WIDTH = 16, PRODUCT_WIDTH = 16, frame 0xFFFF,0x0002(last) -> out_sum = 0x0001, out_overflow = 1.
REQ-035 out_ready = 0 for 5 cycles after a result -> out_* stable, in_ready = 0, next frame's first term held until release.
REQ-036 Continuous single-term frames 10,20,30 with out_ready = 1 -> out_valid stays 1 for 3 cycles, out_sum 10,20,30.
REQ-037 rst pulsed after terms 4,4 of an unfinished frame, then frame 9(last) -> out_sum = 9, out_count = 1.
REQ-038 COUNT_WIDTH = 2, frame of five 1s -> out_count = 3, out_sum = 5, out_overflow = 1.
